// File: rtl/dds_symbol_modulator.sv
// Serialises bytes MSB first onto a DDS carrier (BPSK, ASK/OOK or bypass), one bit per SPS samples.
// Define DIFF_ENCODE_EN for differential BPSK (phase-state flop toggled by each 1 bit).
module dds_symbol_modulator #(
    parameter int SAMPLE_W = 9,
    parameter int DATA_W   = 8,
    parameter int SPS      = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic [SAMPLE_W-1:0]        mod_out,
    output logic                       mod_valid,
    output logic                       symbol_strobe,
    output logic                       busy
);
    localparam int CNT_W = $clog2(SPS);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state, next_state;
    logic [DATA_W-1:0]          shreg;
    logic [IDX_W-1:0]           bit_idx;
    logic [CNT_W-1:0]           sym_cnt;
    logic [1:0]                 mode_q;

    logic                       consume, sym_last, sym_end, byte_end, load, bit_cur;
    logic signed [SAMPLE_W-1:0] neg_s, mod_sample;

`ifdef DIFF_ENCODE_EN
    logic phase_q;
    logic phase_cur;
`endif

    always_comb begin
        consume    = (state == SEND) && sample_valid;
        sym_last   = (sym_cnt == CNT_W'(SPS - 1));
        sym_end    = consume && sym_last;
        byte_end   = sym_end && (bit_idx == '0);
        data_ready = (state == IDLE) || byte_end;
        load       = data_valid && data_ready;
        bit_cur    = shreg[DATA_W-1];

        next_state = state;
        case (state)
            IDLE: if (load) next_state = SEND;
            SEND: if (byte_end && !load) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Negating the most negative code saturates instead of wrapping back to itself.
    always_comb begin
        neg_s = (sample_in == {1'b1, {(SAMPLE_W-1){1'b0}}}) ?
                {1'b0, {(SAMPLE_W-1){1'b1}}} : -sample_in;
`ifdef DIFF_ENCODE_EN
        phase_cur = phase_q ^ ((sym_cnt == '0) && bit_cur);
`endif
        case (mode_q)
            2'b01:   mod_sample = bit_cur ? sample_in : '0;
            2'b10:   mod_sample = sample_in;
`ifdef DIFF_ENCODE_EN
            default: mod_sample = phase_cur ? neg_s : sample_in;
`else
            default: mod_sample = bit_cur ? sample_in : neg_s;
`endif
        endcase
    end

    assign busy = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            sym_cnt       <= '0;
            mode_q        <= '0;
            mod_out       <= '0;
            mod_valid     <= 1'b0;
            symbol_strobe <= 1'b0;
        end else begin
            state         <= next_state;
            mod_valid     <= sample_valid;
            symbol_strobe <= consume && (sym_cnt == '0);
            if (sample_valid)
                mod_out <= (state == SEND) ? mod_sample : '0;

            if (load) begin
                shreg   <= data_in;
                mode_q  <= mode;
                bit_idx <= IDX_W'(DATA_W - 1);
                sym_cnt <= '0;
            end else if (consume) begin
                sym_cnt <= sym_last ? '0 : sym_cnt + CNT_W'(1);
                if (sym_last) begin
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    bit_idx <= bit_idx - IDX_W'(1);
                end
            end
        end
    end

`ifdef DIFF_ENCODE_EN
    always_ff @(posedge clk) begin
        if (rst)
            phase_q <= 1'b0;
        else if (state == SEND && next_state == IDLE)
            phase_q <= 1'b0;
        else if (consume)
            phase_q <= phase_cur;
    end
`endif

endmodule
